sdram_read: RTL and testbench
=============================

SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 Parameter BURST_LEN, 4, words per READ burst; matches mode-register burst length.
REQ-002 Parameter CAS_LAT, 3, CAS latency in clk cycles; matches mode-register setting.
REQ-003 Parameter TRCD, 2, NOP cycles between ACTIVE and first READ.
REQ-004 Parameter TRP, 2, NOP cycles after PRECHARGE before the block releases the bus.
REQ-005 Parameter JOB_BURSTS, 4, bursts per triggered job, i.e. 16 words, all within one row.
REQ-006 clk  in  1  system clock, 50 MHz, SDRAM command clock; one clock, and reset is synchronous and active-high.
REQ-007 rst  in  1  reset; one clock, and reset is synchronous and active-high.
REQ-008 rd_trig  in  1  single-cycle pulse that arms one read job.
REQ-009 rd_en  in  1  arbiter grant; the block drives commands only while this is high.
REQ-010 ref_req  in  1  refresh pending from the refresh block.
REQ-011 rd_req  out  1  bus request to the arbiter.
REQ-012 rd_end  out  1  one-cycle pulse when the bus is released, whether the job finished or was suspended.
REQ-013 rd_cmd  out  4  {CS_N,RAS_N,CAS_N,WE_N}: NOP=0111, ACT=0011, READ=0101, PRE=0010.
REQ-014 rd_addr  out  13  row address on ACT, column address on READ (A10=0), A10=1 on PRE.
REQ-015 rd_ba  out  2  bank; fixed 2'b00.
REQ-016 dq_in  in  16  SDRAM DQ sampled on clk.
REQ-017 rd_data  out  16  captured read word.
REQ-018 rd_data_vld  out  1  rd_data is valid this cycle.
REQ-019 rd_done  out  1  one-cycle pulse when all JOB_BURSTS*BURST_LEN words have been delivered.

Function
REQ-020 rd_trig sets a job-pending flag; any rd_trig received while a job is pending or active is ignored.
REQ-021 rd_req is high while a job is pending and rd_en is low; it falls in the cycle after rd_en rises.
REQ-022 States: IDLE, ACT, TRCD_WAIT, READ, PRE, TRP_WAIT.
- IDLE->ACT on rd_en && pending.
- ACT: issue ACT for 1 cycle with the current row.
- TRCD_WAIT: TRCD NOPs.
- READ: issue READ at burst-count 0, NOP for the remaining BURST_LEN-1 cycles; the column advances by BURST_LEN per burst.
- PRE: issue PRE for 1 cycle.
- TRP_WAIT: TRP NOPs, then pulse rd_end and return to IDLE.
REQ-023 A burst is never truncated: at the last cycle of each burst, if the job is complete or ref_req=1, go to PRE; otherwise issue the next READ in the next cycle, giving back-to-back bursts.
REQ-024 Suspension by ref_req keeps the job pending and keeps the column counter; re-grant re-ACTs the same row and resumes at the saved column.
REQ-025 Read data: dq_in is captured CAS_LAT+1 cycles after each READ command, for BURST_LEN consecutive cycles, with rd_data_vld high for exactly those cycles; use a CAS_LAT+1-deep valid shift pipe.
REQ-026 The data pipe drains independently of the FSM: words still in flight after PRE or rd_end are still delivered.
REQ-027 rd_done pulses in the cycle after the final word's rd_data_vld.
REQ-028 Row counter: 13-bit, increments by 1 on job completion, and wraps 8191->0. The column counter resets to 0 on each new job.
REQ-029 When not in ACT, READ, or PRE, rd_cmd=NOP and rd_addr=0.

Reset
REQ-030 Reset values: rd_cmd=0111, rd_addr=0, rd_ba=0, rd_req=0, rd_end=0, rd_done=0, rd_data=0, rd_data_vld=0, state=IDLE, row=0, col=0, pending=0, pipe cleared.
REQ-031 Reset mid-job abandons the job with no PRE issued; the system reset re-runs SDRAM init.

Structure
REQ-032 A shared package holds the command encodings (NOP/ACT/READ/PRE/REF/MRS), the state encodings, and the address/data widths shared with sdram_write and sdram_top.
REQ-033 One sub-module, sdram_rd_capture: the valid shift pipe plus the data register, parameterised by CAS_LAT.

Verification
REQ-034 rst for 5 cycles, rd_trig, rd_en high 2 cycles after rd_req -> ACT row 0, 2 NOPs, READ at cols 0/4/8/12 back-to-back, PRE, 2 NOPs, rd_end.
REQ-035 Model preloaded with 0x0000..0x000F at row 0 -> 16 rd_data_vld cycles carrying 0x0000..0x000F in order, then rd_done one cycle later.
REQ-036 ref_req raised during burst 1 -> PRE after col 4 burst completes; rd_end pulses; re-grant -> ACT row 0, READ resumes at col 8; 16 words total, no duplicates.
REQ-037 rd_trig pulsed again while active -> ignored; exactly one job and one rd_done.
REQ-038 Row at 8191, job completes -> next job ACTs row 0.
REQ-039 rst asserted during READ -> next cycle all outputs at reset values, rd_data_vld stays low, no rd_done.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, bus widths and
// the read-sequencer state encoding (shared with sdram_write and sdram_top).
package sdram_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam int BA_W   = 2;
    localparam int CMD_W  = 4;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_READ = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_REF  = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

    // A10 selects "all banks" on PRECHARGE and must stay low on READ
    // (no auto-precharge).
    localparam logic [ADDR_W-1:0] A10_BIT = 13'h0400;

    typedef enum logic [2:0] {
        RD_IDLE      = 3'd0,
        RD_ACT       = 3'd1,
        RD_TRCD_WAIT = 3'd2,
        RD_READ      = 3'd3,
        RD_PRE       = 3'd4,
        RD_TRP_WAIT  = 3'd5
    } rd_state_t;

endpackage

// File: rtl/sdram_rd_capture.sv
// Read-data capture: a CAS_LAT+1 deep valid shift pipe plus the data register.
// A word issued in cycle r is sampled off dq_in at the edge CAS_LAT+1 edges
// after the command launch, and shows up on rd_data with rd_data_vld in cycle
// r+CAS_LAT+1. The pipe drains on its own, independent of the sequencer.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int CAS_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_issue,
    input  logic [DATA_W-1:0] dq_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld
);

    // The last stage doubles as the output valid flag.
    logic [CAS_LAT:0] vld_pipe;

    assign rd_data_vld = vld_pipe[CAS_LAT];

    // Shift the per-word valid along and capture dq_in one stage before the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[CAS_LAT-1:0], word_issue};
            if (vld_pipe[CAS_LAT-1]) begin
                rd_data <= dq_in;
            end
        end
    end

endmodule

// File: rtl/sdram_read.sv
// SDRAM read sequencer: one triggered job reads JOB_BURSTS bursts of BURST_LEN
// words from one row (bank 0), yielding the bus to refresh at burst boundaries
// and resuming at the saved column on the next grant.
// Handshake: rd_trig arms a job; rd_req asks the arbiter for the bus while the
// job is pending and rd_en is low; commands are issued only after rd_en is
// seen high in IDLE, and rd_end pulses once the bus is handed back.
module sdram_read
    import sdram_pkg::*;
#(
    parameter int BURST_LEN  = 4,
    parameter int CAS_LAT    = 3,
    parameter int TRCD       = 2,
    parameter int TRP        = 2,
    parameter int JOB_BURSTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_trig,
    input  logic              rd_en,
    input  logic              ref_req,
    output logic              rd_req,
    output logic              rd_end,
    output logic [CMD_W-1:0]  rd_cmd,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [BA_W-1:0]   rd_ba,
    input  logic [DATA_W-1:0] dq_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              rd_done,
    output rd_state_t         state
);

    localparam int JOB_WORDS = JOB_BURSTS * BURST_LEN;
    localparam int CNT_W     = (JOB_WORDS > 1) ? $clog2(JOB_WORDS) : 1;

    localparam logic [7:0]        TRCD_LAST = 8'(TRCD - 1);
    localparam logic [7:0]        TRP_LAST  = 8'(TRP - 1);
    localparam logic [7:0]        BEAT_LAST = 8'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] JOB_COLS  = ADDR_W'(JOB_WORDS);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(JOB_WORDS - 1);

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] col_next;
    logic              pending;
    logic              job_last;
    logic [7:0]        wait_cnt;
    logic [7:0]        beat_cnt;
    logic [CNT_W-1:0]  word_cnt;

    // col is the start column of the burst currently being read.
    assign col_next = col + COL_STEP;
    assign job_last = (col_next == JOB_COLS);
    assign rd_ba    = '0;

    // Command sequencer; rd_cmd/rd_addr are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RD_IDLE;
            rd_cmd   <= CMD_NOP;
            rd_addr  <= '0;
            rd_req   <= 1'b0;
            rd_end   <= 1'b0;
            row      <= '0;
            col      <= '0;
            pending  <= 1'b0;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            rd_cmd  <= CMD_NOP;
            rd_addr <= '0;
            rd_end  <= 1'b0;
            rd_req  <= pending && !rd_en;
            case (state)
                RD_IDLE: begin
                    // A trigger is only accepted with no job pending or in flight.
                    if (rd_trig && !pending) begin
                        pending <= 1'b1;
                        col     <= '0;
                    end
                    if (rd_en && pending) begin
                        state   <= RD_ACT;
                        rd_cmd  <= CMD_ACT;
                        rd_addr <= row;
                    end
                end
                RD_ACT: begin
                    state    <= RD_TRCD_WAIT;
                    wait_cnt <= '0;
                end
                RD_TRCD_WAIT: begin
                    if (wait_cnt == TRCD_LAST) begin
                        state    <= RD_READ;
                        rd_cmd   <= CMD_READ;
                        rd_addr  <= col & ~A10_BIT;
                        beat_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RD_READ: begin
                    // Decisions are taken only at the last beat, so a burst is never cut short.
                    if (beat_cnt == BEAT_LAST) begin
                        if (job_last) begin
                            row     <= row + ADDR_W'(1);
                            col     <= '0;
                            pending <= 1'b0;
                        end else begin
                            col <= col_next;
                        end
                        if (job_last || ref_req) begin
                            state   <= RD_PRE;
                            rd_cmd  <= CMD_PRE;
                            rd_addr <= A10_BIT;
                        end else begin
                            rd_cmd   <= CMD_READ;
                            rd_addr  <= col_next & ~A10_BIT;
                            beat_cnt <= '0;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                RD_PRE: begin
                    state    <= RD_TRP_WAIT;
                    wait_cnt <= '0;
                end
                RD_TRP_WAIT: begin
                    if (wait_cnt == TRP_LAST) begin
                        state  <= RD_IDLE;
                        rd_end <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    // Count delivered words across suspensions; flag the job done after the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            rd_done  <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (rd_data_vld) begin
                if (word_cnt == WORD_LAST) begin
                    word_cnt <= '0;
                    rd_done  <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end
        end
    end

    sdram_rd_capture #(
        .CAS_LAT (CAS_LAT)
    ) u_capture (
        .clk         (clk),
        .rst         (rst),
        .word_issue  (state == RD_READ),
        .dq_in       (dq_in),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld)
    );

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read with a small SDRAM data model and a
// scoreboard of hand-computed expected words.
`timescale 1ns/1ps
module tb_sdram_read;
  import sdram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic        rd_trig = 1'b0;
  logic        rd_en = 1'b0;
  logic        ref_req = 1'b0;
  logic [15:0] dq_in = 16'h0;
  logic        rd_req, rd_end, rd_data_vld, rd_done;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_ba;
  logic [15:0] rd_data;
  rd_state_t   state;

  sdram_read #(
    .BURST_LEN(4), .CAS_LAT(3), .TRCD(2), .TRP(2), .JOB_BURSTS(4)
  ) dut (
    .clk(clk), .rst(rst), .rd_trig(rd_trig), .rd_en(rd_en), .ref_req(ref_req),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .rd_ba(rd_ba), .dq_in(dq_in), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .rd_done(rd_done), .state(state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- SDRAM data model ----------------
  // Word at (row, col) holds {row[11:0], col[3:0]}. A READ seen in cycle r
  // drives word i onto dq_in during cycle r+3+i (CAS latency 3).
  logic [12:0] m_row = 13'h0;
  logic [15:0] m_dat[8] = '{default: 16'h0};
  always @(negedge clk) begin
    logic [12:0] mc;
    for (int k = 0; k < 7; k++) m_dat[k] = m_dat[k+1];
    m_dat[7] = 16'h0;
    if (rd_cmd == CMD_ACT) m_row = rd_addr;
    if (rd_cmd == CMD_READ) begin
      for (int i = 0; i < 4; i++) begin
        mc = rd_addr + 13'(i);
        m_dat[3+i] = {m_row[11:0], mc[3:0]};
      end
    end
    dq_in = m_dat[0];
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] exp_q[$];
  logic [3:0]  ev_cmd[$];
  logic [12:0] ev_addr[$];
  int          ev_cyc[$];
  int          end_cyc[$];
  int          done_cyc[$];
  int          vld_cnt = 0;
  int          extra_words = 0;
  int          first_vld = -1;
  int          last_vld = -1;
  int          nop_addr_bad = 0;
  int          ba_bad = 0;

  always @(negedge clk) begin
    if (rd_cmd != CMD_NOP) begin
      ev_cmd.push_back(rd_cmd);
      ev_addr.push_back(rd_addr);
      ev_cyc.push_back(cyc);
    end else if (rd_addr != 13'h0) begin
      nop_addr_bad++;
    end
    if (rd_ba != 2'b00) ba_bad++;
    if (rd_end) end_cyc.push_back(cyc);
    if (rd_done) done_cyc.push_back(cyc);
    if (rd_data_vld) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      if (exp_q.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      else extra_words++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    exp_q.delete(); ev_cmd.delete(); ev_addr.delete(); ev_cyc.delete();
    end_cyc.delete(); done_cyc.delete();
    vld_cnt = 0; extra_words = 0; first_vld = -1; last_vld = -1;
    nop_addr_bad = 0; ba_bad = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; rd_en = 1'b0; rd_trig = 1'b0; ref_req = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_trig();
    @(negedge clk) rd_trig = 1'b1;
    @(negedge clk) rd_trig = 1'b0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return rd_req;
      1: return rd_end;
      default: return rd_done;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string tag);
    int t = 0;
    while (sig(which) !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_seen"}, 32'(sig(which)), 32'd1);
  endtask

  task automatic wait_events(input int n);
    int t = 0;
    while (ev_cmd.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("event_wait", 32'(ev_cmd.size() >= n), 32'd1);
  endtask

  function automatic int ec(input int i);
    return (i < ev_cyc.size()) ? ev_cyc[i] : -1000;
  endfunction

  task automatic check_ev(input int i, input logic [3:0] cmd, input logic [12:0] addr);
    check($sformatf("ev%0d_cmd", i), 32'((i < ev_cmd.size()) ? ev_cmd[i] : 4'hF), 32'(cmd));
    check($sformatf("ev%0d_addr", i), 32'((i < ev_addr.size()) ? ev_addr[i] : 13'h1FFF), 32'(addr));
  endtask

  function automatic int act_count();
    int n = 0;
    foreach (ev_cmd[i]) if (ev_cmd[i] == CMD_ACT) n++;
    return n;
  endfunction

  task automatic push_words(input logic [15:0] base);
    for (int i = 0; i < 16; i++) exp_q.push_back(base + 16'(i));
  endtask

  task automatic run_job();
    pulse_trig();
    wait_sig(0, "rd_req");
    repeat (2) @(negedge clk);
    rd_en = 1'b1;
    wait_sig(1, "rd_end");
    rd_en = 1'b0;
    wait_sig(2, "rd_done");
    repeat (3) @(negedge clk);
  endtask

  task automatic check_job_tail(input string tag);
    check({tag, "_words"}, 32'(vld_cnt), 32'd16);
    check({tag, "_extra"}, 32'(extra_words), 32'd0);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_dones"}, 32'(done_cyc.size()), 32'd1);
    check({tag, "_nop_addr"}, 32'(nop_addr_bad), 32'd0);
    check({tag, "_ba"}, 32'(ba_bad), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    do_reset(5);
    check("rst_cmd", 32'(rd_cmd), 32'(CMD_NOP));
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_ba", 32'(rd_ba), 32'd0);
    check("rst_req", 32'(rd_req), 32'd0);
    check("rst_end", 32'(rd_end), 32'd0);
    check("rst_done", 32'(rd_done), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_vld", 32'(rd_data_vld), 32'd0);
    check("rst_state", 32'(state), 32'(RD_IDLE));

    // Full job from row 0: command sequence, timing and data
    clear_logs();
    push_words(16'h0000);
    pulse_trig();
    wait_sig(0, "j1_rd_req");
    repeat (2) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    check("j1_req_fall", 32'(rd_req), 32'd0);
    wait_sig(1, "j1_rd_end");
    rd_en = 1'b0;
    wait_sig(2, "j1_rd_done");
    repeat (3) @(negedge clk);
    check("j1_nevents", 32'(ev_cmd.size()), 32'd6);
    check_ev(0, CMD_ACT, 13'd0);
    check_ev(1, CMD_READ, 13'd0);
    check_ev(2, CMD_READ, 13'd4);
    check_ev(3, CMD_READ, 13'd8);
    check_ev(4, CMD_READ, 13'd12);
    check_ev(5, CMD_PRE, 13'h0400);
    check("j1_trcd", 32'(ec(1) - ec(0)), 32'd3);
    check("j1_b2b_1", 32'(ec(2) - ec(1)), 32'd4);
    check("j1_b2b_2", 32'(ec(3) - ec(2)), 32'd4);
    check("j1_b2b_3", 32'(ec(4) - ec(3)), 32'd4);
    check("j1_pre", 32'(ec(5) - ec(4)), 32'd4);
    check("j1_nends", 32'(end_cyc.size()), 32'd1);
    check("j1_trp", 32'((end_cyc.size() > 0) ? end_cyc[0] - ec(5) : -1), 32'd3);
    check("j1_cas", 32'(first_vld - ec(1)), 32'd4);
    check("j1_done_lat", 32'((done_cyc.size() > 0) ? done_cyc[0] - last_vld : -1), 32'd1);
    check_job_tail("j1");

    // Refresh suspension during burst 1, resume at column 8
    do_reset(2);
    clear_logs();
    push_words(16'h0000);
    pulse_trig();
    wait_sig(0, "j2_rd_req");
    rd_en = 1'b1;
    wait_events(3);
    ref_req = 1'b1;
    wait_sig(1, "j2_rd_end1");
    rd_en = 1'b0;
    ref_req = 1'b0;
    check("j2_words_at_susp", 32'(vld_cnt + exp_q.size()), 32'd16);
    wait_sig(0, "j2_rereq");
    rd_en = 1'b1;
    wait_sig(1, "j2_rd_end2");
    rd_en = 1'b0;
    wait_sig(2, "j2_rd_done");
    repeat (3) @(negedge clk);
    check("j2_nevents", 32'(ev_cmd.size()), 32'd8);
    check_ev(0, CMD_ACT, 13'd0);
    check_ev(1, CMD_READ, 13'd0);
    check_ev(2, CMD_READ, 13'd4);
    check_ev(3, CMD_PRE, 13'h0400);
    check_ev(4, CMD_ACT, 13'd0);
    check_ev(5, CMD_READ, 13'd8);
    check_ev(6, CMD_READ, 13'd12);
    check_ev(7, CMD_PRE, 13'h0400);
    check("j2_nends", 32'(end_cyc.size()), 32'd2);
    check_job_tail("j2");

    // Extra triggers while pending and while active are ignored
    do_reset(2);
    clear_logs();
    push_words(16'h0000);
    pulse_trig();
    wait_sig(0, "j3_rd_req");
    pulse_trig();
    rd_en = 1'b1;
    wait_events(2);
    pulse_trig();
    wait_sig(1, "j3_rd_end");
    rd_en = 1'b0;
    wait_sig(2, "j3_rd_done");
    repeat (10) @(negedge clk);
    check("j3_acts", 32'(act_count()), 32'd1);
    check("j3_req_idle", 32'(rd_req), 32'd0);
    check_job_tail("j3");

    // Row counter wrap 8191 -> 0
    do_reset(2);
    @(negedge clk);
    force dut.row = 13'd8191;
    @(negedge clk);
    release dut.row;
    clear_logs();
    push_words(16'hFFF0);
    run_job();
    check_ev(0, CMD_ACT, 13'd8191);
    check_job_tail("j4");
    clear_logs();
    push_words(16'h0000);
    run_job();
    check_ev(0, CMD_ACT, 13'd0);
    check_job_tail("j5");

    // Reset during READ
    do_reset(2);
    clear_logs();
    pulse_trig();
    wait_sig(0, "j6_rd_req");
    rd_en = 1'b1;
    wait_events(3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd", 32'(rd_cmd), 32'(CMD_NOP));
    check("mid_rst_addr", 32'(rd_addr), 32'd0);
    check("mid_rst_vld", 32'(rd_data_vld), 32'd0);
    check("mid_rst_data", 32'(rd_data), 32'd0);
    check("mid_rst_state", 32'(state), 32'(RD_IDLE));
    check("mid_rst_req", 32'(rd_req), 32'd0);
    clear_logs();
    rst = 1'b0;
    rd_en = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_vld", 32'(vld_cnt), 32'd0);
    check("post_rst_done", 32'(done_cyc.size()), 32'd0);
    check("post_rst_cmds", 32'(ev_cmd.size()), 32'd0);
    check("post_rst_req", 32'(rd_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
